// File: rtl/ram_port_arbiter.sv
// Shares one 64-bit RAMHelper port between fetch (I) and load/store (D) requesters.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; default is fixed D-over-I priority.
module ram_port_arbiter #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          IDX_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [63:0] i_req_addr,
  output logic        i_resp_valid,
  input  logic        i_resp_ready,
  output logic [63:0] i_resp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [63:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [63:0] d_req_wdata,
  input  logic [63:0] d_req_wmask,
  output logic        d_resp_valid,
  input  logic        d_resp_ready,
  output logic [63:0] d_resp_data,
  output logic        ram_ren,
  output logic [63:0] ram_ridx,
  input  logic [63:0] ram_rdata,
  output logic        ram_wen,
  output logic [63:0] ram_widx,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  output logic        busy
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // a response transfers on a rising edge where resp_valid & resp_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic        owner_d;
  logic        we_q;
  logic [63:0] idx_q;
  logic [63:0] wdata_q;
  logic [63:0] wmask_q;
  logic [63:0] resp_data;
  logic        ren_q;
  logic        wen_q;
  logic        i_rv_q;
  logic        d_rv_q;
  logic        d_grant;
  logic        i_grant;
  logic        d_write;
  logic [63:0] req_addr;
  logic [63:0] req_idx;

`ifdef RAM_ARB_RR_EN
  logic last_owner;  // 1 = D owned the previous transaction
  assign d_grant = d_req_valid & (~i_req_valid | ~last_owner);
`else
  assign d_grant = d_req_valid;
`endif
  assign i_grant  = i_req_valid & ~d_grant;
  assign d_write  = d_grant & d_req_we;
  assign req_addr = d_grant ? d_req_addr : i_req_addr;
  // Modulo-2^64 subtraction: addresses below the base wrap rather than fault.
  assign req_idx  = (req_addr - BASE_ADDR) >> IDX_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      resp_data <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      i_rv_q    <= 1'b0;
      d_rv_q    <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last_owner <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (d_grant || i_grant) begin
            owner_d <= d_grant;
            idx_q   <= req_idx;
            we_q    <= d_write;
            ren_q   <= ~d_write;
            wen_q   <= d_write;
            if (d_grant) begin
              wdata_q <= d_req_wdata;
              wmask_q <= d_req_wmask;
            end
`ifdef RAM_ARB_RR_EN
            last_owner <= d_grant;
`endif
            state <= ACCESS;
          end
        end
        ACCESS: begin
          resp_data <= we_q ? 64'd0 : ram_rdata;
          ren_q     <= 1'b0;
          wen_q     <= 1'b0;
          i_rv_q    <= ~owner_d;
          d_rv_q    <= owner_d;
          state     <= RESP;
        end
        RESP: begin
          if ((owner_d && d_resp_ready) || (!owner_d && i_resp_ready)) begin
            i_rv_q <= 1'b0;
            d_rv_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_req_ready  = (state == IDLE) & i_grant;
  assign d_req_ready  = (state == IDLE) & d_grant;
  assign i_resp_valid = i_rv_q;
  assign d_resp_valid = d_rv_q;
  assign i_resp_data  = owner_d ? 64'd0 : resp_data;
  assign d_resp_data  = owner_d ? resp_data : 64'd0;
  assign ram_ren      = ren_q;
  assign ram_wen      = wen_q;
  assign ram_ridx     = idx_q;
  assign ram_widx     = idx_q;
  assign ram_wdata    = wdata_q;
  assign ram_wmask    = wmask_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: small RAM model, expected-result queue, grant-order and stall checks.
module tb_ram_port_arbiter;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready;
  logic [63:0] i_req_addr, i_resp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_resp_valid, d_resp_ready;
  logic [63:0] d_req_addr, d_req_wdata, d_req_wmask, d_resp_data;
  logic        ram_ren, ram_wen, busy;
  logic [63:0] ram_ridx, ram_rdata, ram_widx, ram_wdata, ram_wmask;

  logic [63:0] mem [16];
  logic [63:0] exp_mem [16];
  logic        mem_init;
  logic [63:0] exp_q[$];
  int          vectors;
  int          miscompares;

  ram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data),
    .ram_ren(ram_ren), .ram_ridx(ram_ridx), .ram_rdata(ram_rdata),
    .ram_wen(ram_wen), .ram_widx(ram_widx), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
    .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_val(input int i);
    logic [63:0] v;
    v = {32'hC0DE_0000 | 32'(i), 32'h1234_0000 | 32'(i)};
    if (i == 2) v = 64'h0000_0000_DEAD_BEEF;
    return v;
  endfunction

  // RAM model: combinational read, write commits on the rising edge while wen is high
  assign ram_rdata = ram_ren ? mem[ram_ridx[3:0]] : 64'd0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (ram_wen) begin
      mem[ram_widx[3:0]] <= (mem[ram_widx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver: one transaction with resp_ready high, exact-cycle latency checks
  task automatic txn(input bit is_d, input logic [63:0] addr, input bit we,
                     input logic [63:0] wdata, input logic [63:0] wmask);
    logic [63:0] idx;
    int n;
    idx = (addr - BASE) >> 3;
    exp_q.push_back(we ? 64'd0 : exp_mem[idx[3:0]]);
    if (we) exp_mem[idx[3:0]] = (exp_mem[idx[3:0]] & ~wmask) | (wdata & wmask);
    @(negedge clk);
    if (is_d) begin
      d_req_valid = 1'b1; d_req_addr = addr; d_req_we = we;
      d_req_wdata = wdata; d_req_wmask = wmask;
    end else begin
      i_req_valid = 1'b1; i_req_addr = addr;
    end
    n = 0;
    while (!(is_d ? d_req_ready : i_req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready", 64'(is_d ? d_req_ready : i_req_ready), 64'd1);
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    @(negedge clk);
    check_eq("access_en", 64'((is_d && we) ? ram_wen : ram_ren), 64'd1);
    if (we) begin
      check_eq("widx", ram_widx, idx);
      check_eq("wmask", ram_wmask, wmask);
    end else begin
      check_eq("ridx", ram_ridx, idx);
    end
    @(negedge clk);
    check_eq("resp_valid", 64'(is_d ? d_resp_valid : i_resp_valid), 64'd1);
    check_eq("other_resp_valid", 64'(is_d ? i_resp_valid : d_resp_valid), 64'd0);
    check_eq("resp_data", is_d ? d_resp_data : i_resp_data, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        exp_owner [4];
    logic [63:0] held;
    int          n;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; mem_init = 1'b1;
    i_req_valid = 0; i_req_addr = '0; i_resp_ready = 1'b1;
    d_req_valid = 0; d_req_addr = '0; d_req_we = 0; d_req_wdata = '0; d_req_wmask = '0;
    d_resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ren_wen", {62'd0, ram_ren, ram_wen}, 64'd0);
    check_eq("rst_resp_valid", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    check_eq("rst_ridx", ram_ridx, 64'd0);
    check_eq("rst_wdata", ram_wdata, 64'd0);
    rst_n = 1'b1;
    mem_init = 1'b0;

    // directed: fetch of RAM[2], masked write then readback, address wrap / low bits
    txn(1'b0, 64'h8000_0010, 1'b0, '0, '0);
    txn(1'b1, 64'h8000_0008, 1'b1, 64'h1122_3344_5566_7788, 64'hFFFF_FFFF_0000_0000);
    txn(1'b1, 64'h8000_0008, 1'b0, '0, '0);
    txn(1'b0, 64'h7FFF_FFF8, 1'b0, '0, '0);
    txn(1'b1, 64'h8000_0017, 1'b0, '0, '0);

    // random mix
    for (int k = 0; k < 12; k++) begin
      bit d_sel, wr;
      logic [63:0] a;
      d_sel = 1'($urandom_range(0, 1));
      wr = d_sel & 1'($urandom_range(0, 1));
      a = BASE + 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(0, 7));
      txn(d_sel, a, wr, {$urandom, $urandom}, {$urandom, $urandom});
    end

    // reset in the middle of a write to word 5: write must not commit
    @(negedge clk);
    d_req_valid = 1'b1; d_req_addr = BASE + 64'h28; d_req_we = 1'b1;
    d_req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; d_req_wmask = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_wen_before", 64'(ram_wen), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_wen", 64'(ram_wen), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_widx", ram_widx, 64'd0);
    check_eq("abort_wmask", ram_wmask, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_resp_valid", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
    rst_n = 1'b1;
    txn(1'b1, BASE + 64'h28, 1'b0, '0, '0);

    // both valid for four grants, starting from reset
    do_reset();
`ifdef RAM_ARB_RR_EN
    exp_owner = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_owner = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    @(negedge clk);
    i_req_valid = 1'b1; i_req_addr = BASE + 64'h10;
    d_req_valid = 1'b1; d_req_addr = BASE + 64'h18; d_req_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(i_req_ready || d_req_ready) && n < 20) begin
        @(negedge clk);
        n++;
      end
      check_eq("tie_one_grant", 64'(i_req_ready ^ d_req_ready), 64'd1);
      check_eq("tie_owner_d", 64'(d_req_ready), 64'(exp_owner[k]));
      @(posedge clk);
      #1;
      if (k == 3) begin
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check_eq("tie_drain_busy", 64'(busy), 64'd0);

    // D read held in RESP by a stalled consumer while I waits
    exp_q.push_back(exp_mem[3]);
    @(negedge clk);
    d_req_valid = 1'b1; d_req_addr = BASE + 64'h18; d_req_we = 1'b0; d_resp_ready = 1'b0;
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
    i_req_valid = 1'b1; i_req_addr = BASE;
    @(negedge clk);
    @(negedge clk);
    held = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      check_eq("stall_valid", 64'(d_resp_valid), 64'd1);
      check_eq("stall_data", d_resp_data, held);
      check_eq("stall_i_ready", {62'd0, i_req_ready, i_resp_valid}, 64'd0);
      check_eq("stall_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    i_req_valid = 1'b0;
    d_resp_ready = 1'b1;
    @(negedge clk);
    check_eq("stall_release_busy", 64'(busy), 64'd0);
    check_eq("stall_release_valid", 64'(d_resp_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
